// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: recovers left/right words from an external SCK/WS/SD stream into a small AXI-Stream FIFO.
// Define I2S_RX_OVF_COUNTER_EN to implement the saturating dropped-word counter on ovf_count.
module i2s_slave_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck_i,
    input  logic                  ws_i,
    input  logic                  sd_i,
    output logic [DATA_WIDTH-1:0] axis_data,
    output logic                  axis_channel,
    output logic                  axis_valid,
    input  logic                  axis_ready,
    output logic                  overflow,
    output logic                  short_word,
    input  logic                  clear_flags,
    output logic [7:0]            ovf_count
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ALIGN = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic                  sck_prev_q, sck_prev_d;
    logic                  ws_last_q, ws_last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  chan_q, chan_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  push_q, push_d;
    logic [EW-1:0]         push_data_q, push_data_d;
    logic [EW-1:0]         fifo_mem_q [FIFO_DEPTH];
    logic [EW-1:0]         fifo_mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  overflow_q, overflow_d, short_q, short_d;

    logic                  sck_s, ws_s, sd_s, rise, ws_change, short_set;
    logic [CW-1:0]         cnt_inc;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  pop, full, do_write, drop;
    logic [EW-1:0]         head;

    // Bit 2 = SCK, bit 1 = WS, bit 0 = SD; all three see the same synchroniser delay so they stay aligned.
    assign sync1_d    = {sck_i, ws_i, sd_i};
    assign sync2_d    = sync1_q;
    assign sck_s      = sync2_q[2];
    assign ws_s       = sync2_q[1];
    assign sd_s       = sync2_q[0];
    assign sck_prev_d = sck_s;
    assign rise       = sck_s & ~sck_prev_q;
    assign ws_change  = rise & (ws_s != ws_last_q);
    assign cnt_inc    = cnt_q + CW'(1);
    assign shifted    = {shreg_q[DATA_WIDTH-2:0], sd_s};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ALIGN;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaulting every comb output first keeps these blocks free of inferred latches.
        state_d = state_q;
        if (rise) begin
            case (state_q)
                ALIGN:   if (ws_change) state_d = SHIFT;
                SHIFT:   if (!ws_change && cnt_inc == FULL_CNT) state_d = HOLD;
                HOLD:    if (ws_change) state_d = SHIFT;
                default: state_d = ALIGN;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        chan_d      = chan_q;
        shreg_d     = shreg_q;
        ws_last_d   = ws_last_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        short_set   = 1'b0;
        if (rise) begin
            ws_last_d = ws_s;
            case (state_q)
                ALIGN, HOLD: begin
                    if (ws_change) begin
                        cnt_d  = '0;
                        chan_d = ws_s;
                    end
                end
                SHIFT: begin
                    // The bit in the WS-change slot still belongs to the word being closed.
                    shreg_d = shifted;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == FULL_CNT) begin
                        push_d      = 1'b1;
                        push_data_d = {chan_q, shifted};
                    end
                    if (ws_change) begin
                        short_set = (cnt_inc != FULL_CNT);
                        cnt_d     = '0;
                        chan_d    = ws_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // A push arriving while full still lands if the head is popped in the same cycle.
    assign pop      = axis_valid & axis_ready;
    assign full     = (count_q == FULL_LVL);
    assign do_write = push_q & (~full | pop);
    assign drop     = push_q & full & ~pop;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        if (do_write) fifo_mem_d[wr_ptr_q] = push_data_q;
        wr_ptr_d   = wr_ptr_q + AW'(do_write);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW + 1)'(do_write) - (AW + 1)'(pop);
        overflow_d = clear_flags ? 1'b0 : (overflow_q | drop);
        short_d    = clear_flags ? 1'b0 : (short_q | short_set);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sck_prev_q  <= 1'b0;
            ws_last_q   <= 1'b0;
            cnt_q       <= '0;
            chan_q      <= 1'b0;
            shreg_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sck_prev_q  <= sck_prev_d;
            ws_last_q   <= ws_last_d;
            cnt_q       <= cnt_d;
            chan_q      <= chan_d;
            shreg_q     <= shreg_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            short_q     <= short_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count define validity, and the output is gated below.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign head         = fifo_mem_q[rd_ptr_q];
    assign axis_valid   = (count_q != '0);
    assign axis_data    = axis_valid ? head[DATA_WIDTH-1:0] : '0;
    assign axis_channel = axis_valid ? head[DATA_WIDTH] : 1'b0;
    assign overflow     = overflow_q;
    assign short_word   = short_q;

`ifdef I2S_RX_OVF_COUNTER_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clear_flags)                      ovf_cnt_d = '0;
        else if (drop && ovf_cnt_q != 8'hFF)  ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: drives an I2S bit stream and checks recovered beats, flags and latency.
module tb_i2s_slave_rx;

    logic        clk = 1'b0;
    logic        rst, sck_i, ws_i, sd_i, axis_ready, clear_flags;
    logic [15:0] axis_data;
    logic        axis_channel, axis_valid, overflow, short_word;
    logic [7:0]  ovf_count;

    int vectors    = 0;
    int miscompares = 0;
    logic [16:0] beats[$];

    i2s_slave_rx #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
        .axis_data(axis_data), .axis_channel(axis_channel), .axis_valid(axis_valid),
        .axis_ready(axis_ready), .overflow(overflow), .short_word(short_word),
        .clear_flags(clear_flags), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge; the handshake is sampled on the negedge before it completes.
    always @(negedge clk) begin
        if (axis_valid && axis_ready) beats.push_back({axis_channel, axis_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_at(input int i);
        if (i < beats.size()) return 32'(beats[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic ws, input logic sd);
        sck_i = 1'b0; ws_i = ws; sd_i = sd;
        tick(3);
        sck_i = 1'b1;
        tick(3);
    endtask

    function automatic logic bit_of(input logic [31:0] data, input int nbits, input int i);
        if (i < nbits) return data[nbits-1-i];
        return 1'b0;
    endfunction

    // All but the last bit of a slot; the last bit carries the next channel's WS.
    task automatic send_head(input logic ch, input logic [31:0] data, input int nbits, input int slot);
        for (int i = 0; i < slot - 1; i++) send_bit(ch, bit_of(data, nbits, i));
    endtask

    task automatic send_slot(input logic ch, input logic nxt, input logic [31:0] data,
                             input int nbits, input int slot);
        send_head(ch, data, nbits, slot);
        send_bit(nxt, bit_of(data, nbits, slot - 1));
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; sck_i = 1'b0; ws_i = 1'b0; sd_i = 1'b0;
        axis_ready = 1'b1; clear_flags = 1'b0;
        tick(3);
        check("rst_valid", 32'(axis_valid), 32'd0);
        check("rst_data", 32'(axis_data), 32'd0);
        check("rst_chan", 32'(axis_channel), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_short", 32'(short_word), 32'd0);
        check("rst_ovf_cnt", 32'(ovf_count), 32'd0);
        rst = 1'b0;
        tick(2);

        // Mid-word start on the left channel, then full right/left/right words.
        send_slot(1'b0, 1'b1, 32'h16, 5, 5);
        send_slot(1'b1, 1'b0, 32'h0F0F, 16, 16);
        send_slot(1'b0, 1'b1, 32'hA5C3, 16, 16);
        send_slot(1'b1, 1'b0, 32'h1234, 16, 16);
        tick(6);
        check("lr_count", beats.size(), 32'd3);
        check("lr_beat0", beat_at(0), 32'h0001_0F0F);
        check("lr_beat1", beat_at(1), 32'h0000_A5C3);
        check("lr_beat2", beat_at(2), 32'h0001_1234);
        check("lr_ovf", 32'(overflow), 32'd0);
        check("lr_short", 32'(short_word), 32'd0);
        beats.delete();

        // 24-bit slots: only the top 16 bits are kept.
        send_slot(1'b0, 1'b1, 32'hABCDEF, 24, 24);
        send_slot(1'b1, 1'b0, 32'h123456, 24, 24);
        tick(6);
        check("w24_count", beats.size(), 32'd2);
        check("w24_beat0", beat_at(0), 32'h0000_ABCD);
        check("w24_beat1", beat_at(1), 32'h0001_1234);
        check("w24_short", 32'(short_word), 32'd0);
        beats.delete();

        // WS toggles after 10 bits, then a full word.
        send_slot(1'b0, 1'b1, 32'h2AA, 10, 10);
        send_slot(1'b1, 1'b0, 32'hBEEF, 16, 16);
        tick(6);
        check("short_count", beats.size(), 32'd1);
        check("short_beat0", beat_at(0), 32'h0001_BEEF);
        check("short_set", 32'(short_word), 32'd1);
        pulse_clear();
        check("short_clr", 32'(short_word), 32'd0);
        beats.delete();

        // Latency of the first word into an empty FIFO, then overflow with the consumer stalled.
        axis_ready = 1'b0;
        send_head(1'b0, 32'h1111, 16, 16);
        sck_i = 1'b0; ws_i = 1'b1; sd_i = 1'b1;
        tick(3);
        sck_i = 1'b1;
        tick(1);
        check("lat_e0", 32'(axis_valid), 32'd0);
        tick(1);
        check("lat_e1", 32'(axis_valid), 32'd0);
        tick(1);
        check("lat_e2", 32'(axis_valid), 32'd0);
        tick(1);
        check("lat_e3", 32'(axis_valid), 32'd1);
        tick(2);
        send_slot(1'b1, 1'b0, 32'h2222, 16, 16);
        send_slot(1'b0, 1'b1, 32'h3333, 16, 16);
        send_slot(1'b1, 1'b0, 32'h4444, 16, 16);
        send_slot(1'b0, 1'b1, 32'h5555, 16, 16);
        send_slot(1'b1, 1'b0, 32'h6666, 16, 16);
        tick(6);
        check("ovf_flag", 32'(overflow), 32'd1);
`ifdef I2S_RX_OVF_COUNTER_EN
        check("ovf_cnt", 32'(ovf_count), 32'd2);
`else
        check("ovf_cnt", 32'(ovf_count), 32'd0);
`endif
        check("hold_valid", 32'(axis_valid), 32'd1);
        check("hold_data", 32'(axis_data), 32'h1111);
        check("hold_chan", 32'(axis_channel), 32'd0);
        check("hold_none", beats.size(), 32'd0);
        axis_ready = 1'b1;
        tick(8);
        check("drain_count", beats.size(), 32'd4);
        check("drain_beat0", beat_at(0), 32'h0000_1111);
        check("drain_beat1", beat_at(1), 32'h0001_2222);
        check("drain_beat2", beat_at(2), 32'h0000_3333);
        check("drain_beat3", beat_at(3), 32'h0001_4444);
        check("drain_empty", 32'(axis_valid), 32'd0);
        pulse_clear();
        check("ovf_clr", 32'(overflow), 32'd0);
        check("ovf_cnt_clr", 32'(ovf_count), 32'd0);
        beats.delete();

        // Reset mid-word with two entries queued and short_word set.
        axis_ready = 1'b0;
        send_slot(1'b0, 1'b1, 32'h2A, 6, 6);
        send_slot(1'b1, 1'b0, 32'hAAAA, 16, 16);
        send_slot(1'b0, 1'b1, 32'h5555, 16, 16);
        for (int i = 0; i < 8; i++) send_bit(1'b1, i[0]);
        tick(4);
        check("pre_rst_valid", 32'(axis_valid), 32'd1);
        check("pre_rst_short", 32'(short_word), 32'd1);
        sck_i = 1'b0; ws_i = 1'b0; sd_i = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", 32'(axis_valid), 32'd0);
        check("mid_rst_data", 32'(axis_data), 32'd0);
        check("mid_rst_short", 32'(short_word), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        axis_ready = 1'b1;
        tick(6);
        check("post_rst_none", beats.size(), 32'd0);
        send_slot(1'b0, 1'b1, 32'h5, 4, 4);
        send_slot(1'b1, 1'b0, 32'hCAFE, 16, 16);
        tick(6);
        check("realign_count", beats.size(), 32'd1);
        check("realign_beat0", beat_at(0), 32'h0001_CAFE);
        check("realign_short", 32'(short_word), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
